quad2pos: RTL and testbench
===========================

QUAD2POS -- requirements
Module: quad2pos

Interface
REQ-001 Parameter FILT_LEN, default 4, range 1-15: consecutive stable cycles required to accept an encoder level.
REQ-002 Parameter POS_MIN, default 8'h00: lowest position value.
REQ-003 Parameter POS_MAX, default 8'hFF: highest position value; POS_MIN < POS_MAX.
REQ-004 Parameter INIT_POS, default 8'h80: position after reset.
REQ-005 Parameter IDLE_CYC, default 24'd12000000: step-free cycles before active drops.
REQ-006 clk_sys  input  1  sole clock; all state on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 enc_a  input  1  encoder phase A, asynchronous.
REQ-009 enc_b  input  1  encoder phase B, asynchronous.
REQ-010 load  input  1  synchronous position load strobe.
REQ-011 load_val  input  8  value written on load.
REQ-012 pos  output  8  decoded paddle position.
REQ-013 step  output  1  one-cycle pulse per accepted quadrature step.
REQ-014 dir  output  1  direction of last step: 1 = up (+1), 0 = down (-1).
REQ-015 err  output  1  one-cycle pulse on illegal transition (both phases changed).
REQ-016 active  output  1  high while encoder has stepped within the last IDLE_CYC cycles.

Function
REQ-017 enc_a/enc_b SHALL each pass through a two-flop synchronizer before any other logic.
REQ-018 Each synchronized phase SHALL have its own glitch filter: the filtered level takes the synced level on the edge where the synced level has differed from it for FILT_LEN consecutive cycles; any agreeing cycle clears the count to 0.
REQ-019 Decoder SHALL register the previous filtered pair {a,b} and compare each cycle with the current pair.
REQ-020 Up sequence SHALL be 00->01->11->10->00; each such transition gives step=1, dir=1, pos+1.
REQ-021 Down sequence SHALL be 00->10->11->01->00; each such transition gives step=1, dir=0, pos-1.
REQ-022 Unchanged pair SHALL give step=0, err=0; pos and dir hold.
REQ-023 Pair with both bits changed SHALL give err=1, step=0; pos and dir unchanged; previous-pair register takes the new pair.
REQ-024 Latency: an enc change first sampled on edge 1 SHALL update pos/step/dir on edge FILT_LEN+3 if held stable throughout.
REQ-025 Arithmetic is 8-bit unsigned: up at POS_MAX holds POS_MAX, down at POS_MIN holds POS_MIN; step and dir still assert (saturating mode).
REQ-026 load=1 SHALL set pos to load_val clamped into [POS_MIN,POS_MAX] on the next edge; load wins over a simultaneous step, which is dropped from pos but still pulses step/dir.
REQ-027 Idle counter SHALL clear on every step and increment, saturating, otherwise; active=1 on the edge after a step; active=0 when counter reaches IDLE_CYC.
REQ-028 err SHALL NOT affect active or the idle counter.

Reset
REQ-029 On reset: pos=INIT_POS, step=0, dir=1, err=0, active=0; idle counter and filter counts =0.
REQ-030 On reset, synchronizer, filtered and previous-pair registers SHALL load the current raw enc_a/enc_b levels so that release of reset produces no step or err.
REQ-031 Reset asserted mid-filter or mid-step SHALL abort it; no step pulse appears for that transition after release.

Configuration
REQ-032 Macro QUAD2POS_WRAP_EN: when defined, up at POS_MAX SHALL give POS_MIN and down at POS_MIN SHALL give POS_MAX (wrap-around); when undefined, saturation per REQ-025 applies; all other behaviour is identical.

Verification
REQ-033 Defaults, reset released with enc=00; drive 01,11,10,00, each held 10 cycles -> four step pulses, dir=1, pos 8'h80->8'h84, err never high.
REQ-034 From pos=8'h84, drive the down sequence twice around (8 transitions) -> pos=8'h7C, dir=0, 8 step pulses.
REQ-035 Glitch: enc_a pulses high for 3 cycles with FILT_LEN=4 -> no step, pos unchanged; same pulse held for 4 cycles -> exactly one step, on edge 7 after first sample.
REQ-036 Enc 00->11 in one cycle, held -> one err pulse, step=0, pos unchanged; then 11->10 -> step with dir=1.
REQ-037 load=1, load_val=8'hFE, then 3 up steps -> pos=8'hFF (saturate); with QUAD2POS_WRAP_EN defined -> pos=8'h01; load coincident with a step -> pos=load_val.
REQ-038 IDLE_CYC=100: one step -> active=1 on next edge; no further input -> active=0 exactly 100 cycles after the step; reset mid-count -> active=0 immediately.

Source files
------------

// File: rtl/quad2pos.sv
// quad2pos -- quadrature encoder to paddle position decoder.
//
// Raw encoder phases are double-flop synchronized, glitch filtered per phase,
// then decoded as a Gray-code sequence into an 8-bit position with step,
// direction, illegal-transition and activity indications.
//
// Optional build macro:
//   QUAD2POS_WRAP_EN  position wraps POS_MAX<->POS_MIN instead of saturating.
//
// Ports:
//   clk_sys   in   sole clock, all state on rising edge
//   reset     in   synchronous active-high reset
//   enc_a     in   encoder phase A (asynchronous)
//   enc_b     in   encoder phase B (asynchronous)
//   load      in   position load strobe
//   load_val  in   [7:0] value for load (clamped into [POS_MIN,POS_MAX])
//   pos       out  [7:0] decoded position
//   step      out  one-cycle pulse per accepted step
//   dir       out  direction of last step, 1 = up
//   err       out  one-cycle pulse when both phases change together
//   active    out  high while a step occurred within the last IDLE_CYC cycles
module quad2pos #(
    parameter int unsigned FILT_LEN = 4,
    parameter logic [7:0]  POS_MIN  = 8'h00,
    parameter logic [7:0]  POS_MAX  = 8'hFF,
    parameter logic [7:0]  INIT_POS = 8'h80,
    parameter logic [23:0] IDLE_CYC = 24'd12000000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] pos,
    output logic       step,
    output logic       dir,
    output logic       err,
    output logic       active
);

    // Count value on which a persistent disagreement is accepted.
    localparam logic [3:0] FILT_TERM = 4'(FILT_LEN - 1);

    logic [1:0]      raw, sync1, sync2, filt, prev;
    logic [1:0][3:0] fcnt;
    logic            up, dn, bad, step_det;
    logic [7:0]      pos_up, pos_dn, ld_val;
    logic [8:0]      d_lo, d_hi;
    logic [23:0]     idle, idle_next;

    assign raw = {enc_a, enc_b};

    // Reset loads the live encoder level through the whole chain so that
    // releasing reset never looks like a transition.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync1 <= raw;
            sync2 <= raw;
            filt  <= raw;
            prev  <= raw;
            fcnt  <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != filt[i]) begin
                    if (fcnt[i] == FILT_TERM) begin
                        filt[i] <= sync2[i];
                        fcnt[i] <= '0;
                    end else begin
                        fcnt[i] <= fcnt[i] + 4'd1;
                    end
                end else begin
                    fcnt[i] <= '0;
                end
            end
        end
    end

    // Gray-code decode of {prev, current} as {a,b,a,b}.
    always_comb begin
        up  = 1'b0;
        dn  = 1'b0;
        bad = 1'b0;
        case ({prev, filt})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: up  = 1'b1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: dn  = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: bad = 1'b1;
            default: ;
        endcase
    end

    assign step_det = up | dn;

`ifdef QUAD2POS_WRAP_EN
    assign pos_up = (pos == POS_MAX) ? POS_MIN : pos + 8'd1;
    assign pos_dn = (pos == POS_MIN) ? POS_MAX : pos - 8'd1;
`else
    assign pos_up = (pos == POS_MAX) ? POS_MAX : pos + 8'd1;
    assign pos_dn = (pos == POS_MIN) ? POS_MIN : pos - 8'd1;
`endif

    // Clamp via borrow bits, which stays well-defined even when a bound is 0.
    assign d_lo   = {1'b0, load_val} - {1'b0, POS_MIN};
    assign d_hi   = {1'b0, POS_MAX} - {1'b0, load_val};
    assign ld_val = d_lo[8] ? POS_MIN : (d_hi[8] ? POS_MAX : load_val);

    // Idle counter saturates at IDLE_CYC; the step that clears it is the
    // same edge that raises the step pulse, so active follows one edge later.
    assign idle_next = step_det ? 24'd0 : ((idle == IDLE_CYC) ? idle : idle + 24'd1);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pos    <= INIT_POS;
            step   <= 1'b0;
            dir    <= 1'b1;
            err    <= 1'b0;
            active <= 1'b0;
            idle   <= '0;
        end else begin
            step   <= step_det;
            err    <= bad;
            idle   <= idle_next;
            active <= step | (active & (idle_next != IDLE_CYC));
            if (step_det)
                dir <= up;
            // A load overrides the position but the step is still reported.
            if (load)
                pos <= ld_val;
            else if (up)
                pos <= pos_up;
            else if (dn)
                pos <= pos_dn;
        end
    end

endmodule

// File: tb/tb_quad2pos.sv
module tb_quad2pos;

    logic       clk_sys = 1'b0;
    logic       reset, enc_a, enc_b, load;
    logic [7:0] load_val, pos;
    logic       step, dir, err, active;

    always #5 clk_sys = ~clk_sys;

    quad2pos #(.FILT_LEN(4), .IDLE_CYC(24'd100)) dut (
        .clk_sys(clk_sys), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .load(load), .load_val(load_val), .pos(pos), .step(step),
        .dir(dir), .err(err), .active(active)
    );

    int n_chk = 0, n_fail = 0;
    int steps_seen = 0, errs_seen = 0;

    always @(negedge clk_sys) begin
        if (step) steps_seen++;
        if (err)  errs_seen++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        logic       a, b, ld;
        logic [7:0] lv;
        int         exp_pos;
        int         exp_dir;
        int         exp_steps;
        int         exp_errs;
    } vec_t;

    vec_t tbl[20];
    int   s0, e0, p0, first_k, pos7, found;

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'h00, 'h81, 1, 1, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 'h82, 1, 1, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 'h83, 1, 1, 0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 'h84, 1, 1, 0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 'h83, 0, 1, 0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 'h82, 0, 1, 0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 'h81, 0, 1, 0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 'h80, 0, 1, 0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 'h7F, 0, 1, 0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 'h7E, 0, 1, 0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 'h7D, 0, 1, 0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 'h7C, 0, 1, 0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 'h7C, 0, 0, 1};  // illegal 00->11
        tbl[13] = '{1'b1, 1'b0, 1'b0, 8'h00, 'h7D, 1, 1, 0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 'h7E, 1, 1, 0};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 8'hFE, 'hFE, 1, 0, 0};  // load
        tbl[16] = '{1'b0, 1'b1, 1'b0, 8'h00, 'hFF, 1, 1, 0};
`ifdef QUAD2POS_WRAP_EN
        tbl[17] = '{1'b1, 1'b1, 1'b0, 8'h00, 'h00, 1, 1, 0};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 8'h00, 'h01, 1, 1, 0};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 8'h00, 'h02, 1, 1, 0};
`else
        tbl[17] = '{1'b1, 1'b1, 1'b0, 8'h00, 'hFF, 1, 1, 0};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 8'h00, 'hFF, 1, 1, 0};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 8'h00, 'hFF, 1, 1, 0};
`endif

        // Reset with encoder at 00
        reset = 1'b1; enc_a = 1'b0; enc_b = 1'b0; load = 1'b0; load_val = 8'h00;
        repeat (3) @(posedge clk_sys);
        #1;
        check("reset_pos", pos, 'h80);
        check("reset_step", step, 0);
        check("reset_dir", dir, 1);
        check("reset_err", err, 0);
        check("reset_active", active, 0);
        s0 = steps_seen; e0 = errs_seen;
        reset = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        check("release_steps", steps_seen - s0, 0);
        check("release_errs", errs_seen - e0, 0);

        // Table: each vector held 12 cycles (step lands on edge 7)
        for (int i = 0; i < 20; i++) begin
            s0 = steps_seen; e0 = errs_seen;
            enc_a = tbl[i].a; enc_b = tbl[i].b;
            load = tbl[i].ld; load_val = tbl[i].lv;
            @(posedge clk_sys);
            #1;
            load = 1'b0;
            repeat (11) @(posedge clk_sys);
            #1;
            check($sformatf("vec%0d_pos", i), pos, tbl[i].exp_pos);
            check($sformatf("vec%0d_dir", i), dir, tbl[i].exp_dir);
            check($sformatf("vec%0d_steps", i), steps_seen - s0, tbl[i].exp_steps);
            check($sformatf("vec%0d_errs", i), errs_seen - e0, tbl[i].exp_errs);
        end
        p0 = tbl[19].exp_pos;

        // 3-cycle glitch on A: rejected
        s0 = steps_seen;
        enc_a = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        enc_a = 1'b0;
        repeat (12) @(posedge clk_sys);
        #1;
        check("glitch3_steps", steps_seen - s0, 0);
        check("glitch3_pos", pos, p0);

        // 4-cycle pulse on A: accepted, first step exactly on edge 7
        first_k = 0; pos7 = 0;
        enc_a = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk_sys);
            #1;
            if (k == 4) enc_a = 1'b0;
            if (step && first_k == 0) first_k = k;
            if (k == 7) pos7 = pos;
        end
        check("pulse4_step_edge", first_k, 7);
        check("pulse4_pos", pos7, (p0 - 1) & 255);
        repeat (12) @(posedge clk_sys);
        #1;
        check("pulse4_return_pos", pos, p0);

        // Reset mid-filter and while active: aborts the pending step
        check("active_before_reset", active, 1);
        enc_b = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        reset = 1'b1;
        @(posedge clk_sys);
        #1;
        check("reset_mid_active", active, 0);
        check("reset_mid_pos", pos, 'h80);
        reset = 1'b0;
        s0 = steps_seen;
        repeat (15) @(posedge clk_sys);
        #1;
        check("reset_mid_steps", steps_seen - s0, 0);

        // Idle timeout: 01 -> 11 up step, then quiet
        found = 0;
        enc_a = 1'b1;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(posedge clk_sys);
            #1;
            if (step) found = 1;
        end
        check("idle_step_seen", found, 1);
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk_sys);
            #1;
            if (k == 1)   check("active_after_step", active, 1);
            if (k == 99)  check("active_at_99", active, 1);
            if (k == 100) check("active_at_100", active, 0);
        end
        check("idle_pos", pos, 'h81);

        // Load coincident with a step (11 -> 10 up)
        enc_b = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk_sys);
            #1;
            if (k == 6) begin
                load = 1'b1; load_val = 8'h33;
            end
        end
        check("load_step_pulse", step, 1);
        check("load_step_pos", pos, 'h33);
        check("load_step_dir", dir, 1);
        load = 1'b0;
        @(posedge clk_sys);
        #1;
        check("load_step_hold", pos, 'h33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
